// File: rtl/pattern_det_sched.sv
// Round-robin scheduler that time-shares one serial BBCBC detector step across N_CH streams.
// Define PDS_HIT_COUNT_EN to add per-channel saturating hit counters (cnt_sel_i / cnt_o).
module pattern_det_sched #(
  parameter int N_CH = 4,
  parameter int CH_W = 2,
  parameter int SW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] d_i,
  input  logic [N_CH-1:0] clear_i,
  output logic [N_CH-1:0] gnt_o,
  output logic            det_valid_o,
  output logic            det_d_o,
  output logic [SW-1:0]   det_ctx_o,
  output logic [CH_W-1:0] det_ch_o,
  input  logic [SW-1:0]   det_next_i,
  input  logic            det_hit_i,
`ifdef PDS_HIT_COUNT_EN
  input  logic [CH_W-1:0] cnt_sel_i,
  output logic [7:0]      cnt_o,
`endif
  output logic [N_CH-1:0] hit_o
);

  logic [SW-1:0]   ctx [N_CH];
  logic [CH_W-1:0] rr_ptr;

  logic [N_CH-1:0] elig_p0;
  logic            found_p0;
  logic [CH_W-1:0] win_p0;
  logic [CH_W-1:0] idx_p0;

  // ---- stage p0: eligibility, round-robin search, detector operand mux ----
  always_comb begin
    elig_p0  = (en_i && rst) ? (req_i & ~clear_i) : '0;
    found_p0 = 1'b0;
    win_p0   = '0;
    idx_p0   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx_p0 = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (!found_p0 && elig_p0[idx_p0]) begin
        found_p0 = 1'b1;
        win_p0   = idx_p0;
      end
    end
    gnt_o = '0;
    if (found_p0) gnt_o[win_p0] = 1'b1;
    det_valid_o = found_p0;
    det_d_o     = found_p0 ? d_i[win_p0] : 1'b0;
    det_ctx_o   = found_p0 ? ctx[win_p0] : '0;
    det_ch_o    = win_p0;
  end

  // ---- stage p1: commit detector result into context, pointer and hit pulse ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
      hit_o  <= '0;
      for (int k = 0; k < N_CH; k++) ctx[k] <= '0;
    end else begin
      hit_o <= '0;
      if (found_p0) begin
        ctx[win_p0]   <= det_next_i;
        hit_o[win_p0] <= det_hit_i;
        rr_ptr        <= (win_p0 == CH_W'(N_CH - 1)) ? '0 : win_p0 + 1'b1;
      end
      // Cleared channels are never granted, so this cannot collide with the commit above.
      for (int k = 0; k < N_CH; k++)
        if (clear_i[k]) ctx[k] <= '0;
    end
  end

`ifdef PDS_HIT_COUNT_EN
  logic [7:0] cnt [N_CH];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- stage p2: hit counters follow the registered hit pulse ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (clear_i[k])    cnt[k] <= '0;
        else if (hit_o[k]) cnt[k] <= sat_inc(cnt[k]);
      end
    end
  end

  assign cnt_o = cnt[cnt_sel_i];
`endif

endmodule

// File: tb/tb_pattern_det_sched.sv
// Directed bench for pattern_det_sched, paired with a BBCBC (0,0,1,0,1) detector step model.
module tb_pattern_det_sched;
  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int SW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            en_i;
  logic [N_CH-1:0] req_i, d_i, clear_i;
  logic [N_CH-1:0] gnt_o, hit_o;
  logic            det_valid_o, det_d_o;
  logic [SW-1:0]   det_ctx_o;
  logic [CH_W-1:0] det_ch_o;
  logic [SW-1:0]   ref_next;
  logic            ref_hit;
`ifdef PDS_HIT_COUNT_EN
  logic [CH_W-1:0] cnt_sel_i;
  logic [7:0]      cnt_o;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_det_sched #(.N_CH(N_CH), .CH_W(CH_W), .SW(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .req_i       (req_i),
    .d_i         (d_i),
    .clear_i     (clear_i),
    .gnt_o       (gnt_o),
    .det_valid_o (det_valid_o),
    .det_d_o     (det_d_o),
    .det_ctx_o   (det_ctx_o),
    .det_ch_o    (det_ch_o),
    .det_next_i  (ref_next),
    .det_hit_i   (ref_hit),
`ifdef PDS_HIT_COUNT_EN
    .cnt_sel_i   (cnt_sel_i),
    .cnt_o       (cnt_o),
`endif
    .hit_o       (hit_o)
  );

  // Reference detector: state = length of matched prefix of 0,0,1,0,1 (overlapping).
  always_comb begin
    ref_next = 3'd0;
    ref_hit  = 1'b0;
    case (det_ctx_o)
      3'd0: ref_next = det_d_o ? 3'd0 : 3'd1;
      3'd1: ref_next = det_d_o ? 3'd0 : 3'd2;
      3'd2: ref_next = det_d_o ? 3'd3 : 3'd2;
      3'd3: ref_next = det_d_o ? 3'd0 : 3'd4;
      3'd4: begin
        ref_next = det_d_o ? 3'd0 : 3'd2;
        ref_hit  = det_d_o;
      end
      default: ref_next = 3'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic pbit(input int j);
    return (j == 2) || (j == 4);
  endfunction

  task automatic clear_all();
    req_i   = '0;
    clear_i = '1;
    tick();
    clear_i = '0;
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    req_i = '0;
    tick();
    rst   = 1'b1;
  endtask

  // Feed one 5-bit pattern on channel ch; hit expected after the last bit.
  task automatic send_pattern(input int ch, input string tag);
    for (int j = 0; j < 5; j++) begin
      req_i = N_CH'(1 << ch);
      d_i   = pbit(j) ? N_CH'(1 << ch) : '0;
      mid();
      chk({tag, "_gnt"}, 32'(gnt_o), 32'(1 << ch));
      tick();
      chk({tag, "_hit"}, 32'(hit_o), (j == 4) ? 32'(1 << ch) : 32'h0);
    end
    req_i = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; en_i = 1'b1; req_i = 4'hF; d_i = '0; clear_i = '0;
`ifdef PDS_HIT_COUNT_EN
    cnt_sel_i = 2'd3;
`endif
    // 1: reset holds off grants even with all requests up
    mid();
    chk("rst_gnt0", 32'(gnt_o), 32'h0);
    tick();
    chk("rst_hit", 32'(hit_o), 32'h0);
    mid();
    chk("rst_gnt1", 32'(gnt_o), 32'h0);
    tick();
    rst = 1'b1;
    mid();
    chk("post_rst_gnt", 32'(gnt_o), 32'h1);
    chk("post_rst_ctx", 32'(det_ctx_o), 32'h0);
    chk("post_rst_vld", 32'(det_valid_o), 32'h1);
    tick();

    // 2: single channel 1 pattern, one-cycle hit
    clear_all();
    for (int j = 0; j < 5; j++) begin
      req_i = 4'b0010;
      d_i   = pbit(j) ? 4'b0010 : 4'b0000;
      mid();
      chk("t2_gnt", 32'(gnt_o), 32'h2);
      chk("t2_ch", 32'(det_ch_o), 32'h1);
      chk("t2_d", 32'(det_d_o), 32'(pbit(j)));
      tick();
      chk("t2_hit", 32'(hit_o), (j == 4) ? 32'h2 : 32'h0);
    end
    req_i = '0;
    mid();
    chk("t2_idle_vld", 32'(det_valid_o), 32'h0);
    chk("t2_idle_ch", 32'(det_ch_o), 32'h0);
    tick();
    chk("t2_hit_gone", 32'(hit_o), 32'h0);

    // 3: full load round-robin order
    do_reset();
    req_i = 4'hF;
    d_i   = '0;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("t3_ch", 32'(det_ch_o), 32'(i % 4));
      chk("t3_gnt", 32'(gnt_o), 32'(1 << (i % 4)));
      tick();
    end
    req_i = '0;

    // 4: channels 0 and 2 interleave their patterns
    do_reset();
    begin
      int i0, i2;
      i0 = 0;
      i2 = 0;
      for (int c = 0; c < 10; c++) begin
        req_i = 4'b0101;
        d_i   = {1'b0, pbit(i2), 1'b0, pbit(i0)};
        mid();
        chk("t4_gnt", 32'(gnt_o), (c % 2 == 0) ? 32'h1 : 32'h4);
        tick();
        if (c % 2 == 0) i0++;
        else i2++;
        chk("t4_hit", 32'(hit_o), (c == 8) ? 32'h1 : (c == 9) ? 32'h4 : 32'h0);
      end
    end
    req_i = '0;

    // 5: clear wins over a pending request and resets the context
    clear_all();
    for (int j = 0; j < 3; j++) begin
      req_i = 4'b0100;
      d_i   = pbit(j) ? 4'b0100 : 4'b0000;
      mid();
      chk("t5_pre_gnt", 32'(gnt_o), 32'h4);
      tick();
    end
    clear_i = 4'b0100;
    req_i   = 4'b0100;
    d_i     = '0;
    mid();
    chk("t5_clr_gnt", 32'(gnt_o), 32'h0);
    chk("t5_clr_vld", 32'(det_valid_o), 32'h0);
    chk("t5_clr_ctx", 32'(det_ctx_o), 32'h0);
    tick();
    clear_i = '0;
    for (int j = 3; j < 5; j++) begin
      req_i = 4'b0100;
      d_i   = pbit(j) ? 4'b0100 : 4'b0000;
      mid();
      tick();
      chk("t5_nohit", 32'(hit_o), 32'h0);
    end
    send_pattern(2, "t5_full");

    // 6: enable drop mid-pattern preserves context
    clear_all();
    for (int j = 0; j < 3; j++) begin
      req_i = 4'b1000;
      d_i   = pbit(j) ? 4'b1000 : 4'b0000;
      mid();
      tick();
    end
    en_i  = 1'b0;
    req_i = 4'b1000;
    d_i   = '0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("t6_off_gnt", 32'(gnt_o), 32'h0);
      tick();
      chk("t6_off_hit", 32'(hit_o), 32'h0);
    end
    en_i = 1'b1;
    for (int j = 3; j < 5; j++) begin
      req_i = 4'b1000;
      d_i   = pbit(j) ? 4'b1000 : 4'b0000;
      mid();
      chk("t6_gnt", 32'(gnt_o), 32'h8);
      if (j == 3) chk("t6_ctx_kept", 32'(det_ctx_o), 32'h3);
      tick();
      chk("t6_hit", 32'(hit_o), (j == 4) ? 32'h8 : 32'h0);
    end
    req_i = '0;

`ifdef PDS_HIT_COUNT_EN
    clear_all();
    chk("cnt_clr", 32'(cnt_o), 32'h0);
    for (int p = 0; p < 256; p++) send_pattern(3, "cnt");
    tick();
    tick();
    chk("cnt_255", 32'(cnt_o), 32'hFF);
    send_pattern(3, "cnt_sat");
    tick();
    tick();
    chk("cnt_sat", 32'(cnt_o), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
